// File: rtl/rx_frame_sync_pkg.sv
// rx_frame_sync_pkg: shared Rx framing constants and state encoding
package rx_frame_sync_pkg;
  localparam int CODE_W = 14;
  localparam logic [1:0] FRAME_HDR = 2'b11;
  typedef enum logic [1:0] {GAP, HDR, PAYLOAD} state_t;
endpackage

// File: rtl/rx_bit_timeout.sv
// rx_bit_timeout: strobe-restarted cycle counter with a one-cycle expiry pulse
module rx_bit_timeout #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  input  logic strobe,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] cnt_q, cnt_d;
  // expiry when the idle count reaches its limit; a strobe in that cycle wins
  always_comb begin
    expire = en && !strobe && cnt_q == LAST;
    cnt_d = (!en || strobe || expire) ? '0 : cnt_q + 1'b1;
  end
  // idle-cycle counter register
  always_ff @(posedge sys_clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rx_frame_sync.sv
// rx_frame_sync: finds gap+header framing and deserialises the Hamming codeword MSB-first
module rx_frame_sync
  import rx_frame_sync_pkg::*;
#(
  parameter int GAP_BITS    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [CODE_W-1:0] hammingcode,
  output logic              code_valid,
  output logic              frame_err,
  output logic              sync_lock
);
  localparam int ZW = $clog2(GAP_BITS + 1);
  localparam int BW = $clog2(CODE_W + 1);
  localparam logic [ZW-1:0] GAP_MAX = ZW'(GAP_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(CODE_W - 1);
  state_t state_q, state_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [CODE_W-1:0] sr_q, sr_d, hammingcode_q, hammingcode_d;
  logic code_valid_q, code_valid_d, frame_err_q, frame_err_d, sync_lock_q, sync_lock_d;
  logic tmo;
  rx_bit_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .sys_clk(sys_clk),
    .rst    (rst),
    .en     (state_q != GAP),
    .strobe (bit_valid),
    .expire (tmo)
  );
  // framing FSM: gap counting, header match, payload shift and abort on stall
  always_comb begin
    state_d = state_q;
    zcnt_d = zcnt_q;
    bcnt_d = bcnt_q;
    sr_d = sr_q;
    hammingcode_d = hammingcode_q;
    code_valid_d = 1'b0;
    frame_err_d = 1'b0;
    sync_lock_d = sync_lock_q;
    if (tmo) begin
      state_d = GAP;
      zcnt_d = '0;
      sync_lock_d = 1'b0;
      frame_err_d = 1'b1;
    end else if (bit_valid) begin
      unique case (state_q)
        GAP: begin
          zcnt_d = (bit_in == FRAME_HDR[1]) ? '0 : (zcnt_q == GAP_MAX) ? zcnt_q : zcnt_q + 1'b1;
          state_d = (bit_in == FRAME_HDR[1] && zcnt_q == GAP_MAX) ? HDR : GAP;
        end
        HDR: begin
          state_d = (bit_in == FRAME_HDR[0]) ? PAYLOAD : GAP;
          zcnt_d = (bit_in == FRAME_HDR[0]) ? zcnt_q : ZW'(1);
          sync_lock_d = (bit_in == FRAME_HDR[0]);
          bcnt_d = '0;
        end
        PAYLOAD: begin
          sr_d = {sr_q[CODE_W-2:0], bit_in};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BIT) begin
            hammingcode_d = sr_d;
            code_valid_d = 1'b1;
            sync_lock_d = 1'b0;
            state_d = GAP;
            zcnt_d = '0;
          end
        end
        default: state_d = GAP;
      endcase
    end
  end
  // state and output registers
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q <= GAP;
      zcnt_q <= '0;
      bcnt_q <= '0;
      sr_q <= '0;
      hammingcode_q <= '0;
      code_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      sync_lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q <= zcnt_d;
      bcnt_q <= bcnt_d;
      sr_q <= sr_d;
      hammingcode_q <= hammingcode_d;
      code_valid_q <= code_valid_d;
      frame_err_q <= frame_err_d;
      sync_lock_q <= sync_lock_d;
    end
  end
  assign hammingcode = hammingcode_q;
  assign code_valid = code_valid_q;
  assign frame_err = frame_err_q;
  assign sync_lock = sync_lock_q;
endmodule

// File: tb/tb_rx_frame_sync.sv
// tb_rx_frame_sync: directed self-checking bench for rx_frame_sync
module tb_rx_frame_sync;
  import rx_frame_sync_pkg::*;
  logic sys_clk = 1'b0;
  logic rst = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic [CODE_W-1:0] hammingcode;
  logic code_valid, frame_err, sync_lock;
  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  always #5 sys_clk = ~sys_clk;
  rx_frame_sync #(.GAP_BITS(2), .TIMEOUT_CYC(4096)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .hammingcode(hammingcode),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .sync_lock  (sync_lock)
  );
  always @(posedge sys_clk) begin
    #1;
    if (code_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
  end
  task automatic strobe(input logic b);
    @(negedge sys_clk);
    bit_valid = 1'b1;
    bit_in = b;
    @(negedge sys_clk);
    bit_valid = 1'b0;
  endtask
  task automatic send(input logic b);
    strobe(b);
    repeat (6) @(negedge sys_clk);
  endtask
  task automatic send_hdr();
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
  endtask
  task automatic send_code(input logic [13:0] c);
    for (int i = 13; i >= 0; i--) send(c[i]);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    checks++;
    if ({hammingcode, code_valid, frame_err, sync_lock} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {hammingcode, code_valid, frame_err, sync_lock});
    end
  endtask
  task automatic test_basic();
    logic [13:0] p;
    int c0;
    p = 14'b10110011100101;
    c0 = cv_cnt;
    send(1'b0); send(1'b0);
    strobe(1'b1);
    checks++;
    if (sync_lock !== 1'b0) begin errors++; $display("FAIL basic_lock_early got %b want 0", sync_lock); end
    repeat (6) @(negedge sys_clk);
    strobe(1'b1);
    checks++;
    if (sync_lock !== 1'b1) begin errors++; $display("FAIL basic_lock_hdr got %b want 1", sync_lock); end
    repeat (6) @(negedge sys_clk);
    for (int i = 13; i >= 1; i--) send(p[i]);
    checks++;
    if (sync_lock !== 1'b1 || code_valid !== 1'b0) begin
      errors++; $display("FAIL basic_before_last got lock=%b cv=%b want 1 0", sync_lock, code_valid);
    end
    strobe(p[0]);
    checks++;
    if (code_valid !== 1'b1 || hammingcode !== 14'h2CE5) begin
      errors++; $display("FAIL basic_code got cv=%b hc=%h want 1 2ce5", code_valid, hammingcode);
    end
    checks++;
    if (sync_lock !== 1'b0) begin errors++; $display("FAIL basic_unlock got %b want 0", sync_lock); end
    @(negedge sys_clk);
    checks++;
    if (code_valid !== 1'b0) begin errors++; $display("FAIL basic_cv_pulse got %b want 0", code_valid); end
    repeat (5) @(negedge sys_clk);
    checks++;
    if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL basic_cv_count got %0d want 1", cv_cnt - c0); end
  endtask
  task automatic test_noise_header();
    int c0, f0;
    c0 = cv_cnt;
    f0 = fe_cnt;
    send(1'b0); send(1'b0); send(1'b1); send(1'b0);
    checks++;
    if (sync_lock !== 1'b0 || fe_cnt !== f0) begin
      errors++; $display("FAIL noise_reject got lock=%b fe=%0d want 0 0", sync_lock, fe_cnt - f0);
    end
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    checks++;
    if (sync_lock !== 1'b1) begin errors++; $display("FAIL noise_relock got %b want 1", sync_lock); end
    send_code(14'h1234);
    checks++;
    if (hammingcode !== 14'h1234 || cv_cnt - c0 !== 1 || fe_cnt !== f0) begin
      errors++; $display("FAIL noise_code got hc=%h cv=%0d fe=%0d want 1234 1 0", hammingcode, cv_cnt - c0, fe_cnt - f0);
    end
  endtask
  task automatic test_no_gap();
    int f0;
    test_reset();
    f0 = fe_cnt;
    send(1'b0); send(1'b1); send(1'b1); send(1'b1);
    checks++;
    if (sync_lock !== 1'b0 || fe_cnt !== f0) begin
      errors++; $display("FAIL nogap_lock got lock=%b fe=%0d want 0 0", sync_lock, fe_cnt - f0);
    end
    send_hdr();
    checks++;
    if (sync_lock !== 1'b1) begin errors++; $display("FAIL nogap_relock got %b want 1", sync_lock); end
    send_code(14'h0F0F);
    checks++;
    if (hammingcode !== 14'h0F0F) begin errors++; $display("FAIL nogap_code got %h want 0f0f", hammingcode); end
  endtask
  task automatic test_timeout();
    int n, f0, c0;
    logic seen;
    f0 = fe_cnt;
    c0 = cv_cnt;
    send_hdr();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    strobe(1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(negedge sys_clk);
      n++;
      seen = frame_err;
    end
    checks++;
    if (!seen || n !== 4096) begin errors++; $display("FAIL timeout_delay got seen=%b cycles=%0d want 1 4096", seen, n); end
    checks++;
    if (sync_lock !== 1'b0 || hammingcode !== 14'h0F0F || code_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_state got lock=%b hc=%h cv=%b want 0 0f0f 0", sync_lock, hammingcode, code_valid);
    end
    @(negedge sys_clk);
    checks++;
    if (frame_err !== 1'b0 || fe_cnt - f0 !== 1 || cv_cnt !== c0) begin
      errors++; $display("FAIL timeout_pulse got fe=%b fecnt=%0d cv=%0d want 0 1 0", frame_err, fe_cnt - f0, cv_cnt - c0);
    end
    send_hdr();
    send_code(14'h2AAA);
    checks++;
    if (hammingcode !== 14'h2AAA || cv_cnt - c0 !== 1) begin
      errors++; $display("FAIL timeout_recover got hc=%h cv=%0d want 2aaa 1", hammingcode, cv_cnt - c0);
    end
  endtask
  task automatic test_back_to_back();
    int c0;
    c0 = cv_cnt;
    send_hdr();
    send_code(14'h3FFF);
    checks++;
    if (hammingcode !== 14'h3FFF || cv_cnt - c0 !== 1 || sync_lock !== 1'b0) begin
      errors++; $display("FAIL b2b_first got hc=%h cv=%0d lock=%b want 3fff 1 0", hammingcode, cv_cnt - c0, sync_lock);
    end
    send_hdr();
    send_code(14'h0001);
    checks++;
    if (hammingcode !== 14'h0001 || cv_cnt - c0 !== 2) begin
      errors++; $display("FAIL b2b_second got hc=%h cv=%0d want 0001 2", hammingcode, cv_cnt - c0);
    end
  endtask
  task automatic test_reset_mid();
    int c0, f0;
    logic [13:0] p;
    p = 14'h1555;
    c0 = cv_cnt;
    f0 = fe_cnt;
    send_hdr();
    for (int i = 13; i >= 7; i--) send(p[i]);
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    rst = 1'b1;
    checks++;
    if ({hammingcode, code_valid, frame_err, sync_lock} !== 17'd0) begin
      errors++; $display("FAIL midrst_outputs got %h want 0", {hammingcode, code_valid, frame_err, sync_lock});
    end
    repeat (60) @(negedge sys_clk);
    checks++;
    if (cv_cnt !== c0 || fe_cnt !== f0) begin
      errors++; $display("FAIL midrst_no_pulse got cv=%0d fe=%0d want 0 0", cv_cnt - c0, fe_cnt - f0);
    end
    send_hdr();
    send_code(14'h0ABC);
    checks++;
    if (hammingcode !== 14'h0ABC || cv_cnt - c0 !== 1) begin
      errors++; $display("FAIL midrst_recover got hc=%h cv=%0d want 0abc 1", hammingcode, cv_cnt - c0);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_noise_header();
    test_no_gap();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
